pc_gen: RTL and testbench

//   Parametrised fetch-PC generator for the LoongArch front end; successor of the fixed +8 PC register.

---
 rtl/pc_gen.sv | 85 ++++++++
 tb/tb_pc_gen.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch-PC generator. It offers one fetch-group address per cycle over a valid/ready handshake.
// Redirects take effect on the next cycle, and sequential fetch steps to the next group boundary.
module pc_gen #(
  parameter int unsigned PC_WIDTH    = 64,
  parameter int unsigned FETCH_BYTES = 8,
  parameter logic [63:0] RESET_PC    = 64'h1c000000
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_misalign,
  input  logic                i_exc_valid,
  input  logic [PC_WIDTH-1:0] i_exc_pc,
  input  logic                i_br_valid,
  input  logic [PC_WIDTH-1:0] i_br_pc,
  input  logic                i_pred_valid,
  input  logic [PC_WIDTH-1:0] i_pred_pc,
  input  logic                i_halt
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0] GROUP_BYTES = PC_WIDTH'(FETCH_BYTES);
  localparam logic [PC_WIDTH-1:0] GROUP_MASK  = ~(GROUP_BYTES - PC_WIDTH'(1));
  localparam logic [PC_WIDTH-1:0] BOOT_PC     = RESET_PC[PC_WIDTH-1:0];

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                misalign_q, misalign_d;
  logic                fire;
  logic [PC_WIDTH-1:0] seq_pc;

  assign o_valid    = (state_q == RUN);
  assign o_pc       = pc_q;
  assign o_misalign = misalign_q;
  assign fire       = o_valid & i_ready;

  // Realign before stepping so a mid-group target resumes at the next boundary.
  assign seq_pc = (pc_q & GROUP_MASK) + GROUP_BYTES;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (i_exc_valid) begin
      pc_d    = i_exc_pc;
      state_d = RUN;
    end else if (i_br_valid) begin
      pc_d    = i_br_pc;
      state_d = RUN;
    end else begin
      case (state_q)
        BOOT: state_d = RUN;
        RUN: begin
          if (i_halt) begin
            state_d = HALT;
          end else if (fire) begin
            pc_d = i_pred_valid ? i_pred_pc : seq_pc;
          end
        end
        HALT:    state_d = HALT;
        default: state_d = BOOT;
      endcase
    end
    misalign_d = (pc_d[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= BOOT_PC;
      misalign_q <= (BOOT_PC[1:0] != 2'b00);
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen. It drives a default 64-bit/8-byte instance and a 32-bit/16-byte instance,
// then checks each against hand-computed values.
module tb_pc_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        rst_n, ready, exc_v, br_v, pred_v, halt;
  logic [63:0] exc_pc, br_pc, pred_pc;
  logic [63:0] pc;
  logic        valid, misalign;

  pc_gen u_dut (
    .clk(clk), .rst_n(rst_n), .o_pc(pc), .o_valid(valid), .i_ready(ready),
    .o_misalign(misalign), .i_exc_valid(exc_v), .i_exc_pc(exc_pc),
    .i_br_valid(br_v), .i_br_pc(br_pc), .i_pred_valid(pred_v),
    .i_pred_pc(pred_pc), .i_halt(halt)
  );

  // Instance B: 32-bit PC, 16-byte groups
  logic        rst2_n, ready2, exc2_v, br2_v, pred2_v, halt2;
  logic [31:0] exc2_pc, br2_pc, pred2_pc;
  logic [31:0] pc2;
  logic        valid2, misalign2;

  pc_gen #(.PC_WIDTH(32), .FETCH_BYTES(16)) u_dut32 (
    .clk(clk), .rst_n(rst2_n), .o_pc(pc2), .o_valid(valid2), .i_ready(ready2),
    .o_misalign(misalign2), .i_exc_valid(exc2_v), .i_exc_pc(exc2_pc),
    .i_br_valid(br2_v), .i_br_pc(br2_pc), .i_pred_valid(pred2_v),
    .i_pred_pc(pred2_pc), .i_halt(halt2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-16s 0x%0h", tag, got);
    end else begin
      $display("FAIL %-16s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_a(input string tag, input logic [63:0] epc,
                          input logic evalid, input logic emis);
    check({tag, ".pc"}, pc, epc);
    check({tag, ".valid"}, {63'd0, valid}, {63'd0, evalid});
    check({tag, ".mis"}, {63'd0, misalign}, {63'd0, emis});
  endtask

  initial begin
    rst_n = 1'b0; ready = 1'b1; exc_v = 1'b0; br_v = 1'b0; pred_v = 1'b0; halt = 1'b0;
    exc_pc = '0; br_pc = '0; pred_pc = '0;
    rst2_n = 1'b0; ready2 = 1'b0; exc2_v = 1'b0; br2_v = 1'b0; pred2_v = 1'b0; halt2 = 1'b0;
    exc2_pc = '0; br2_pc = '0; pred2_pc = '0;

    step(); step();
    expect_a("reset", 64'h1c000000, 1'b0, 1'b0);

    // Boot: valid rises one cycle after release, and the first fire steps by 8.
    rst_n = 1'b1;
    step(); expect_a("boot", 64'h1c000000, 1'b1, 1'b0);
    step(); expect_a("seq1", 64'h1c000008, 1'b1, 1'b0);

    // Back-pressure holds the address and valid.
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); expect_a($sformatf("stall%0d", i), 64'h1c000008, 1'b1, 1'b0);
    end
    ready = 1'b1;
    step(); expect_a("resume", 64'h1c000010, 1'b1, 1'b0);

    // A branch redirect ignores the handshake.
    br_v = 1'b1; br_pc = 64'h1c000104; ready = 1'b0;
    step(); expect_a("br", 64'h1c000104, 1'b1, 1'b0);
    br_v = 1'b0; ready = 1'b1;
    step(); expect_a("br_seq", 64'h1c000108, 1'b1, 1'b0);

    // When exc and br arrive together, exc wins.
    exc_v = 1'b1; exc_pc = 64'h1c008000; br_v = 1'b1; br_pc = 64'h1c000200;
    step(); expect_a("exc_br", 64'h1c008000, 1'b1, 1'b0);
    exc_v = 1'b0; br_v = 1'b0;

    // A misaligned mid-group target is flagged, then the next fetch continues at the group boundary.
    br_v = 1'b1; br_pc = 64'h1c000106;
    step(); expect_a("br_mid", 64'h1c000106, 1'b1, 1'b1);
    br_v = 1'b0;
    step(); expect_a("mid_seq", 64'h1c000108, 1'b1, 1'b0);

    // A prediction is taken on a fire and ignored otherwise.
    pred_v = 1'b1; pred_pc = 64'h1c004000;
    step(); expect_a("pred", 64'h1c004000, 1'b1, 1'b0);
    ready = 1'b0; pred_pc = 64'h1c005000;
    step(); expect_a("pred_nofire", 64'h1c004000, 1'b1, 1'b0);
    pred_v = 1'b0;

    // Halt drops valid and freezes the PC, and ready is ignored while halted.
    halt = 1'b1;
    step(); expect_a("halt", 64'h1c004000, 1'b0, 1'b0);
    halt = 1'b0;
    step(); expect_a("halt_hold", 64'h1c004000, 1'b0, 1'b0);
    ready = 1'b1;
    step(); expect_a("halt_rdy", 64'h1c004000, 1'b0, 1'b0);
    exc_v = 1'b1; exc_pc = 64'h1c000002;
    step(); expect_a("halt_exc", 64'h1c000002, 1'b1, 1'b1);
    exc_v = 1'b0;
    step(); expect_a("exc_seq", 64'h1c000008, 1'b1, 1'b0);

    // Reset mid-operation overrides a pending redirect.
    rst_n = 1'b0; br_v = 1'b1; br_pc = 64'h1c000300;
    step(); expect_a("rst_mid", 64'h1c000000, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(); expect_a("boot_br", 64'h1c000300, 1'b1, 1'b0);
    br_v = 1'b0;

    // 32-bit / 16-byte instance: wrap at the top group, then take a prediction.
    step(); step();
    check("w32.reset", {32'd0, pc2}, 64'h1c000000);
    rst2_n = 1'b1; br2_v = 1'b1; br2_pc = 32'hFFFFFFF0;
    step();
    check("w32.br", {32'd0, pc2}, 64'hFFFFFFF0);
    check("w32.valid", {63'd0, valid2}, 64'd1);
    br2_v = 1'b0; ready2 = 1'b1;
    step();
    check("w32.wrap", {32'd0, pc2}, 64'h0);
    step();
    check("w32.seq", {32'd0, pc2}, 64'h10);
    pred2_v = 1'b1; pred2_pc = 32'h12345670;
    step();
    check("w32.pred", {32'd0, pc2}, 64'h12345670);
    check("w32.mis", {63'd0, misalign2}, 64'd0);
    pred2_v = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
